// File: rtl/cjb_nchan_rr_mux_v_if.sv
// Handshake bundle for the m-channel registered mux.
// slave = the mux itself, master = whoever drives the channels and consumes f.
interface cjb_nchan_rr_mux_v_if #(
  parameter int n  = 8,
  parameter int m  = 4,
  parameter int sw = 2
);
  logic [m*n-1:0] d;
  logic [m-1:0]   d_valid;
  logic [m-1:0]   d_ready;
  logic           mode;
  logic [sw-1:0]  s;
  logic [n-1:0]   f;
  logic [sw-1:0]  f_ch;
  logic           f_valid;
  logic           f_ready;

  modport slave (
    input  d, d_valid, mode, s, f_ready,
    output d_ready, f, f_ch, f_valid
  );

  modport master (
    output d, d_valid, mode, s, f_ready,
    input  d_ready, f, f_ch, f_valid
  );
endinterface

// File: rtl/cjb_nchan_rr_mux_v.sv
// m-channel, n-bit registered mux with direct or round-robin selection.
// One output register stage; full throughput when downstream is always ready.
module cjb_nchan_rr_mux_v #(
  parameter int n  = 8,
  parameter int m  = 4,
  parameter int sw = 2
) (
  input  logic                clock,
  input  logic                resetn,
  cjb_nchan_rr_mux_v_if.slave bus,
  output logic [sw-1:0]       dbg_ptr_o
);

  // Handshake rule on every channel and on f: a word moves on a rising edge
  // exactly when valid && ready; valid never waits for ready.

  logic [n-1:0]  f_q, f_d;
  logic [sw-1:0] f_ch_q, f_ch_d;
  logic          f_valid_q, f_valid_d;
  logic [sw-1:0] ptr_q, ptr_d;

  logic          ld;
  logic [m-1:0]  gnt;
  logic          gnt_any;
  logic [sw-1:0] gnt_idx;
  logic [n-1:0]  gnt_data;
  logic [sw:0]   rr_cand;
  logic          rr_found;
  logic [sw-1:0] rr_idx;

  assign ld = !f_valid_q || bus.f_ready;

  always_comb begin
    gnt      = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    if (!bus.mode) begin
      if ({1'b0, bus.s} < (sw+1)'(m)) begin
        gnt[bus.s] = bus.d_valid[bus.s] & ld;
      end
    end else begin
      // Scan from ptr upward; the candidate index wraps back below m.
      for (int i = 0; i < m; i++) begin
        rr_cand = {1'b0, ptr_q} + (sw+1)'(i);
        if (rr_cand >= (sw+1)'(m)) begin
          rr_cand = rr_cand - (sw+1)'(m);
        end
        if (!rr_found && bus.d_valid[rr_cand[sw-1:0]]) begin
          rr_found = 1'b1;
          rr_idx   = rr_cand[sw-1:0];
        end
      end
      gnt[rr_idx] = rr_found & ld;
    end
  end

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int k = 0; k < m; k++) begin
      if (gnt[k]) begin
        gnt_idx  = sw'(k);
        gnt_data = bus.d[k*n +: n];
      end
    end
  end

  assign gnt_any = |gnt;

  always_comb begin
    f_d       = f_q;
    f_ch_d    = f_ch_q;
    f_valid_d = f_valid_q;
    ptr_d     = ptr_q;
    if (gnt_any) begin
      f_d       = gnt_data;
      f_ch_d    = gnt_idx;
      f_valid_d = 1'b1;
      if (bus.mode) begin
        ptr_d = (gnt_idx == sw'(m-1)) ? '0 : gnt_idx + sw'(1);
      end
    end else if (f_valid_q && bus.f_ready) begin
      f_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      f_q       <= '0;
      f_ch_q    <= '0;
      f_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      f_q       <= f_d;
      f_ch_q    <= f_ch_d;
      f_valid_q <= f_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  // Ready is forced low while reset is held, independent of the grant path.
  assign bus.d_ready = resetn ? gnt : '0;
  assign bus.f       = f_q;
  assign bus.f_ch    = f_ch_q;
  assign bus.f_valid = f_valid_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_cjb_nchan_rr_mux_v.sv
// Bench for cjb_nchan_rr_mux_v: directed scenarios then random traffic,
// checked against a transaction-level model and an output scoreboard.
module tb_cjb_nchan_rr_mux_v;
  localparam int N  = 8;
  localparam int M  = 4;
  localparam int SW = 2;

  logic          clock;
  logic          resetn;
  logic [SW-1:0] dbg_ptr;

  cjb_nchan_rr_mux_v_if #(.n(N), .m(M), .sw(SW)) bus ();

  cjb_nchan_rr_mux_v #(.n(N), .m(M), .sw(SW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_ptr_o (dbg_ptr)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard and model state
  int n_checks = 0;
  int n_fail   = 0;
  logic [SW+N-1:0] exp_q[$];
  int       m_ptr;
  int       m_ch;
  logic [N-1:0] m_f;
  logic     m_fv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] chan_word(input int k);
    logic [M*N-1:0] dv;
    dv = bus.d;
    return dv[k*N +: N];
  endfunction

  // Who should be granted this cycle, straight from the selection rules; -1 = none.
  function automatic int exp_grant();
    int c;
    if (m_fv && !bus.f_ready) return -1;
    if (!bus.mode) begin
      if (int'(bus.s) < M && bus.d_valid[bus.s]) return int'(bus.s);
      return -1;
    end
    for (int i = 0; i < M; i++) begin
      c = (m_ptr + i) % M;
      if (bus.d_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_ch  = 0;
    m_f   = '0;
    m_fv  = 1'b0;
    exp_q.delete();
  endtask

  // driver: inputs are already set by the caller; check, clock, check
  task automatic step();
    int g;
    logic [SW+N-1:0] front;
    #1;
    g = exp_grant();
    chk("d_ready", {28'd0, bus.d_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
    if (m_fv && bus.f_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        front = exp_q.pop_front();
        chk("sb_out", {22'd0, bus.f_ch, bus.f}, {22'd0, front});
      end
    end
    @(posedge clock);
    if (g >= 0) begin
      m_f  = chan_word(g);
      m_ch = g;
      m_fv = 1'b1;
      if (bus.mode) m_ptr = (g + 1) % M;
      exp_q.push_back({SW'(g), m_f});
    end else if (m_fv && bus.f_ready) begin
      m_fv = 1'b0;
    end
    #1;
    chk("f_valid", {31'd0, bus.f_valid}, {31'd0, m_fv});
    chk("f",       {24'd0, bus.f},       {24'd0, m_f});
    chk("f_ch",    {30'd0, bus.f_ch},    32'(m_ch));
    chk("ptr",     {30'd0, dbg_ptr},     32'(m_ptr));
  endtask

  task automatic drive(input logic md, input logic [SW-1:0] sel,
                       input logic [M-1:0] dv, input logic fr);
    bus.mode    = md;
    bus.s       = sel;
    bus.d_valid = dv;
    bus.f_ready = fr;
  endtask

  initial begin
    int seq [6] = '{0, 1, 2, 3, 0, 1};

    model_reset();
    resetn      = 1'b0;
    bus.d       = {8'h44, 8'h33, 8'h22, 8'h11};
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    repeat (2) @(posedge clock);
    #2;
    chk("rst_f",       {24'd0, bus.f},       32'd0);
    chk("rst_f_valid", {31'd0, bus.f_valid}, 32'd0);
    chk("rst_d_ready", {28'd0, bus.d_ready}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    drive(1'b1, 2'd0, 4'b0000, 1'b1);
    repeat (5) step();

    // round-robin fairness from ptr=0
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq",   {30'd0, bus.f_ch}, 32'(seq[i]));
      chk("rr_valid", {31'd0, bus.f_valid}, 32'd1);
    end

    // direct mode
    drive(1'b0, 2'd2, 4'b1111, 1'b1);
    step();
    chk("dir_f",  {24'd0, bus.f},    32'h33);
    chk("dir_ch", {30'd0, bus.f_ch}, 32'd2);
    drive(1'b0, 2'd3, 4'b0111, 1'b1);
    step();
    chk("dir_nogrant", {31'd0, bus.f_valid}, 32'd0);

    // wrap and skip: ptr is still 2 after direct mode
    drive(1'b1, 2'd0, 4'b0100, 1'b1);
    step();
    chk("wrap_ptr3", {30'd0, dbg_ptr}, 32'd3);
    drive(1'b1, 2'd0, 4'b0010, 1'b1);
    step();
    chk("skip_ch1",  {30'd0, bus.f_ch}, 32'd1);
    chk("skip_ptr2", {30'd0, dbg_ptr},  32'd2);
    drive(1'b1, 2'd0, 4'b1000, 1'b1);
    step();
    chk("wrap_ch3",  {30'd0, bus.f_ch}, 32'd3);
    chk("wrap_ptr0", {30'd0, dbg_ptr},  32'd0);

    // backpressure: park f=22 from ch1 and stall
    drive(1'b1, 2'd0, 4'b0001, 1'b1);
    step();
    drive(1'b1, 2'd0, 4'b0010, 1'b1);
    step();
    chk("bp_f", {24'd0, bus.f}, 32'h22);
    drive(1'b1, 2'd0, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_f",   {24'd0, bus.f},    32'h22);
      chk("bp_hold_ptr", {30'd0, dbg_ptr},  32'd2);
    end
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    step();
    chk("bp_release_ch", {30'd0, bus.f_ch}, 32'd2);

    // async reset pulse between edges while streaming
    repeat (3) step();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_f_valid", {31'd0, bus.f_valid}, 32'd0);
    chk("arst_f",       {24'd0, bus.f},       32'd0);
    chk("arst_d_ready", {28'd0, bus.d_ready}, 32'd0);
    model_reset();
    #2;
    resetn = 1'b1;
    step();
    chk("arst_first_ch", {30'd0, bus.f_ch}, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.d = {$urandom, $urandom};
      drive(($urandom_range(0, 3) != 0), SW'($urandom_range(0, 3)),
            M'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
